systolic_tile_pe: RTL and testbench



---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_mac.sv | 44 ++++
 rtl/systolic_tile_pe.sv | 81 ++++++++
 tb/tb_systolic_tile_pe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic tile PE and its MAC.
// The SYSTOLIC_SATURATE_EN build option is consumed by systolic_mac.
package systolic_pkg;

    localparam int DW = 4;
    localparam int AW = 12;

    localparam logic [7:0] UIO_OE_MASK = 8'hF3;

    localparam int COL_CTRL_BIT     = 3;
    localparam int ROW_CTRL_BIT     = 2;
    localparam int COL_CTRL_OUT_BIT = 1;
    localparam int ROW_CTRL_OUT_BIT = 0;

    // Readout nibble selector: walks the accumulator from low to high nibble.
    typedef enum logic [1:0] {
        RC_LO  = 2'd0,
        RC_MID = 2'd1,
        RC_HI  = 2'd2
    } rc_e;

endpackage

// File: rtl/systolic_mac.sv
// Signed DW x DW multiply with AW-bit accumulate.
// Define SYSTOLIC_SATURATE_EN to clamp on overflow instead of wrapping.
module systolic_mac
    import systolic_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 fire,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [AW-1:0] acc
);

    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW:0]     sum_wide;
    logic signed [AW-1:0]   acc_next;

    always_comb begin
        prod     = a * b;
        prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
        // One guard bit: the two top bits disagree exactly on signed overflow.
        sum_wide = {acc[AW-1], acc} + {prod_ext[AW-1], prod_ext};
`ifdef SYSTOLIC_SATURATE_EN
        if (sum_wide[AW] != sum_wide[AW-1]) begin
            acc_next = sum_wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            acc_next = sum_wide[AW-1:0];
        end
`else
        acc_next = sum_wide[AW-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (ena && fire) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/systolic_tile_pe.sv
// One systolic PE tile on the TinyTapeout pinout: operand forwarding, MAC and
// serial nibble readout of the accumulator. Build option: SYSTOLIC_SATURATE_EN.
module systolic_tile_pe
    import systolic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [DW-1:0]        col_q;
    logic [DW-1:0]        row_q;
    logic                 col_v_q;
    logic                 row_v_q;
    rc_e                  rc_q;
    rc_e                  rc_next;
    logic signed [AW-1:0] acc;
    logic [DW-1:0]        nib;
    logic                 fire;
    logic                 unused_uio;

    assign fire       = uio_in[COL_CTRL_BIT] & uio_in[ROW_CTRL_BIT];
    assign unused_uio = ^{uio_in[7:4], uio_in[1:0]};

    systolic_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .fire  (fire),
        .a     ($signed(ui_in[2*DW-1:DW])),
        .b     ($signed(ui_in[DW-1:0])),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            col_v_q <= 1'b0;
            row_v_q <= 1'b0;
            rc_q    <= RC_LO;
        end else if (ena) begin
            col_q   <= ui_in[2*DW-1:DW];
            row_q   <= ui_in[DW-1:0];
            col_v_q <= uio_in[COL_CTRL_BIT];
            row_v_q <= uio_in[ROW_CTRL_BIT];
            rc_q    <= rc_next;
        end
    end

    always_comb begin
        case (rc_q)
            RC_LO:   rc_next = RC_MID;
            RC_MID:  rc_next = RC_HI;
            default: rc_next = RC_LO;
        endcase
    end

    always_comb begin
        case (rc_q)
            RC_LO:   nib = acc[DW-1:0];
            RC_MID:  nib = acc[2*DW-1:DW];
            default: nib = acc[3*DW-1:2*DW];
        endcase
    end

    always_comb begin
        uo_out                    = {col_q, row_q};
        uio_out                   = '0;
        uio_out[7:4]              = nib;
        uio_out[COL_CTRL_OUT_BIT] = col_v_q;
        uio_out[ROW_CTRL_OUT_BIT] = row_v_q;
        uio_oe                    = UIO_OE_MASK;
    end

endmodule

// File: tb/tb_systolic_tile_pe.sv
// Self-checking bench for systolic_tile_pe: per-cycle model comparison plus
// directed literal checks, including a 2x2 chained array.
module tb_systolic_tile_pe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    systolic_tile_pe dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    // 2x2 chain: t00 feeds row to t01 and column to t10; t11 takes both.
    logic [3:0] c0, c1, r0, r1;
    logic       cv0, cv1, rv0, rv1;
    logic [7:0] uo00, uo01, uo10, uo11;
    logic [7:0] uio00, uio01, uio10, uio11;
    logic [7:0] oe00, oe01, oe10, oe11;

    systolic_tile_pe t00 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in({c0, r0}), .uo_out(uo00),
        .uio_in({4'b0, cv0, rv0, 2'b0}), .uio_out(uio00), .uio_oe(oe00)
    );
    systolic_tile_pe t01 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in({c1, uo00[3:0]}), .uo_out(uo01),
        .uio_in({4'b0, cv1, uio00[0], 2'b0}), .uio_out(uio01), .uio_oe(oe01)
    );
    systolic_tile_pe t10 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in({uo00[7:4], r1}), .uo_out(uo10),
        .uio_in({4'b0, uio00[1], rv1, 2'b0}), .uio_out(uio10), .uio_oe(oe10)
    );
    systolic_tile_pe t11 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in({uo01[7:4], uo10[3:0]}), .uo_out(uo11),
        .uio_in({4'b0, uio01[1], uio10[0], 2'b0}), .uio_out(uio11), .uio_oe(oe11)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_acc;   // accumulator as a plain integer in [-2048, 2047]
    int         m_n;     // enabled cycles since reset
    logic [7:0] m_uo;
    logic [1:0] m_ctrl;

    function automatic int sx4(input logic [3:0] v);
        return int'($signed(v));
    endfunction

    function automatic int acc_step(input int acc, input int p);
        int s;
        s = acc + p;
`ifdef SYSTOLIC_SATURATE_EN
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
`else
        if (s > 2047) s = s - 4096;
        else if (s < -2048) s = s + 4096;
`endif
        return s;
    endfunction

    function automatic logic [3:0] exp_nib(input int acc, input int n);
        logic [11:0] bits;
        bits = acc[11:0];
        return bits[4*(n%3) +: 4];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc  <= 0;
            m_n    <= 0;
            m_uo   <= 8'h00;
            m_ctrl <= 2'b00;
        end else if (ena) begin
            m_uo   <= ui_in;
            m_ctrl <= uio_in[3:2];
            m_n    <= m_n + 1;
            if (uio_in[3] && uio_in[2])
                m_acc <= acc_step(m_acc, sx4(ui_in[7:4]) * sx4(ui_in[3:0]));
        end
    end

    always @(negedge clk) begin
        check("cyc_uo_out", {8'h00, uo_out}, {8'h00, m_uo});
        check("cyc_uio_out", {8'h00, uio_out}, {8'h00, exp_nib(m_acc, m_n), 2'b00, m_ctrl});
        check("cyc_uio_oe", {8'h00, uio_oe}, 16'h00F3);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [7:0] ui, input logic [7:0] uio, input logic en);
        ui_in  = ui;
        uio_in = uio;
        ena    = en;
        @(negedge clk);
    endtask

    task automatic read_acc(output logic [11:0] v);
        v = '0;
        for (int i = 0; i < 3; i++) begin
            v[4*(m_n%3) +: 4] = uio_out[7:4];
            step(8'h00, 8'h00, 1'b1);
        end
    endtask

    task automatic read_chain(output logic [11:0] v00, output logic [11:0] v01,
                              output logic [11:0] v10, output logic [11:0] v11);
        v00 = '0; v01 = '0; v10 = '0; v11 = '0;
        for (int i = 0; i < 3; i++) begin
            v00[4*(m_n%3) +: 4] = uio00[7:4];
            v01[4*(m_n%3) +: 4] = uio01[7:4];
            v10[4*(m_n%3) +: 4] = uio10[7:4];
            v11[4*(m_n%3) +: 4] = uio11[7:4];
            step(8'h00, 8'h00, 1'b1);
        end
    endtask

    logic [3:0]  cvals [2][3];
    logic [3:0]  rvals [2][3];
    logic [11:0] v, w00, w01, w10, w11;

    initial begin
        cvals = '{'{4'h3, 4'hE, 4'h1}, '{4'hC, 4'h5, 4'h2}};
        rvals = '{'{4'h2, 4'h7, 4'hD}, '{4'hF, 4'h8, 4'h6}};
        c0 = '0; c1 = '0; r0 = '0; r1 = '0;
        cv0 = 1'b0; cv1 = 1'b0; rv0 = 1'b0; rv1 = 1'b0;

        // Reset with busy inputs
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'hA5;
        uio_in = 8'hFF;
        repeat (2) @(negedge clk);
        check("reset_uo_out", {8'h00, uo_out}, 16'h0000);
        check("reset_uio_out", {8'h00, uio_out}, 16'h0000);
        check("reset_uio_oe", {8'h00, uio_oe}, 16'h00F3);
        rst_n = 1'b1;

        // Pass-through with only column valid
        step(8'h5A, 8'h08, 1'b1);
        check("pass_uo_out", {8'h00, uo_out}, 16'h005A);
        check("pass_ctrl", {14'h0, uio_out[1:0]}, 16'h0002);
        read_acc(v);
        check("pass_no_mac", {4'h0, v}, 16'h0000);

        // Single MAC 3 * -2
        step(8'h3E, 8'h0C, 1'b1);
        read_acc(v);
        check("single_mac", {4'h0, v}, 16'h0FFA);

        // Asynchronous reset mid-cycle loses the accumulator
        step(8'h77, 8'h0C, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_uo_out", {8'h00, uo_out}, 16'h0000);
        check("midrst_uio_out", {8'h00, uio_out}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        read_acc(v);
        check("midrst_acc", {4'h0, v}, 16'h0000);

        // Overflow: 32 x (-8 * -8) = 2048
        repeat (32) step(8'h88, 8'h0C, 1'b1);
        read_acc(v);
`ifdef SYSTOLIC_SATURATE_EN
        check("overflow", {4'h0, v}, 16'h07FF);
`else
        check("overflow", {4'h0, v}, 16'h0800);
`endif

        // Freeze: ena low with both ctrl high and changing data
        for (int i = 0; i < 5; i++) step(8'h91 + 8'(i * 17), 8'h0C, 1'b0);
        read_acc(v);
`ifdef SYSTOLIC_SATURATE_EN
        check("freeze_acc", {4'h0, v}, 16'h07FF);
`else
        check("freeze_acc", {4'h0, v}, 16'h0800);
`endif

        // 2x2 chain with one-cycle skew on the second row/column
        rst_n = 1'b0;
        step(8'h00, 8'h00, 1'b1);
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            cv0 = (t < 3);
            rv0 = (t < 3);
            cv1 = (t >= 1 && t < 4);
            rv1 = (t >= 1 && t < 4);
            c0  = cv0 ? cvals[0][t]   : 4'h0;
            r0  = rv0 ? rvals[0][t]   : 4'h0;
            c1  = cv1 ? cvals[1][t-1] : 4'h0;
            r1  = rv1 ? rvals[1][t-1] : 4'h0;
            step(8'h00, 8'h00, 1'b1);
        end
        read_chain(w00, w01, w10, w11);
        check("chain_t00", {4'h0, w00}, 16'h0FF5);
        check("chain_t01", {4'h0, w01}, 16'h0015);
        check("chain_t10", {4'h0, w10}, 16'h0013);
        check("chain_t11", {4'h0, w11}, 16'h0FE8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
